// File: rtl/serial_twos_complement_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_twos_complement_if
// Description : Serial bit stream bundle for the bit-serial negator.
//               master = upstream shifter / downstream consumer side,
//               slave  = the negator itself.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_twos_complement_if;
    logic inp;        // serial data bit, LSB first
    logic out;        // registered negated bit
    logic word_done;  // registered last-bit-of-word pulse

    modport master (
        output inp,
        input  out,
        input  word_done
    );

    modport slave (
        input  inp,
        output out,
        output word_done
    );
endinterface
`default_nettype wire

// File: rtl/serial_twos_complement.sv
`default_nettype none
// ============================================================================
// Module      : serial_twos_complement
// Description : Bit-serial two's-complement negator. Bits pass through
//               unchanged up to and including the first 1; every later bit
//               is inverted. Output is registered, so there is no
//               combinational path from inp to out.
//               Optional macro TWOC_WORD_FRAME_EN adds a WORD_WIDTH-bit word
//               framer: the state clears itself at each word boundary and a
//               word_done pulse marks the last bit. Without it, word_done is
//               tied low and every word must be preceded by a reset.
// Revision    : 1.0  initial release
// ============================================================================
module serial_twos_complement #(
    parameter int WORD_WIDTH = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    serial_twos_complement_if.slave bus
);

    // Reject illegal word widths at elaboration time.
    generate
        if (WORD_WIDTH < 2) begin : g_bad_word_width
            $error("serial_twos_complement: WORD_WIDTH must be >= 2");
        end
    endgenerate

    // PASS: no 1 seen yet in this word; INVERT: a 1 has been seen.
    typedef enum logic [0:0] {
        PASS   = 1'b0,
        INVERT = 1'b1
    } state_t;

    state_t r_seen_one;
    logic   r_out;

`ifdef TWOC_WORD_FRAME_EN
    localparam int                 C_CNT_W    = $clog2(WORD_WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WORD_WIDTH - 1);

    logic [C_CNT_W-1:0] r_bit_cnt;
    logic               r_word_done;
    logic               w_last_bit;

    // High on the edge that consumes the final bit of a word.
    assign w_last_bit = (r_bit_cnt == C_LAST_BIT);

    // Negator FSM plus word framer; the last bit still uses the pre-edge
    // state for its output, then the state clears for the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen_one  <= PASS;
            r_out       <= 1'b0;
            r_word_done <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_out       <= (r_seen_one == INVERT) ? ~bus.inp : bus.inp;
            r_word_done <= w_last_bit;
            if (w_last_bit) begin
                r_bit_cnt  <= '0;
                r_seen_one <= PASS;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (bus.inp) begin
                    r_seen_one <= INVERT;
                end
            end
        end
    end

    assign bus.word_done = r_word_done;
`else
    // Negator FSM; INVERT is absorbing until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen_one <= PASS;
            r_out      <= 1'b0;
        end else begin
            r_out <= (r_seen_one == INVERT) ? ~bus.inp : bus.inp;
            if (bus.inp) begin
                r_seen_one <= INVERT;
            end
        end
    end

    // No framing: word boundaries are defined by the reset that precedes
    // each word, so there is nothing to flag.
    assign bus.word_done = 1'b0;
`endif

    assign bus.out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_complement.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_twos_complement
// Description : Scoreboard bench for serial_twos_complement. The driver
//               feeds words LSB first and pushes the expected bit of the
//               arithmetic negation (-word mod 2^16) per consumed edge; a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_twos_complement;

    localparam int W = 16;

`ifdef TWOC_WORD_FRAME_EN
    localparam bit FRAME = 1'b1;
`else
    localparam bit FRAME = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_twos_complement_if bus();

    serial_twos_complement #(.WORD_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        exp_out;
        logic        exp_wd;
        logic [15:0] word;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Apply one edge worth of inputs and record what the DUT must show after it.
    task automatic step(input logic r, input logic b, input logic eo,
                        input logic ewd, input logic [15:0] w, input int idx);
        exp_t e;
        reset   = r;
        bus.inp = b;
        @(posedge clk);
        e.exp_out = eo;
        e.exp_wd  = ewd;
        e.word    = w;
        e.idx     = idx;
        q.push_back(e);
        #1;
    endtask

    // Reset edge with a random data bit; output and pulse must read 0.
    task automatic do_reset();
        logic b;
        b = 1'($urandom_range(0, 1));
        step(1'b1, b, 1'b0, 1'b0, 16'h0000, -1);
    endtask

    // Feed the first nbits of w; expected bits come from plain negation.
    task automatic feed(input logic [15:0] w, input int nbits);
        logic [15:0] neg;
        neg = 16'(-w);
        for (int i = 0; i < nbits; i++) begin
            step(1'b0, w[i], neg[i], FRAME && (i == W - 1), w, i);
        end
    endtask

    // Monitor: compare every recorded expectation after its edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.out !== e.exp_out) begin
                errors++;
                $display("FAIL out word=%h bit=%0d got=%b expected=%b",
                         e.word, e.idx, bus.out, e.exp_out);
            end
            checks++;
            if (bus.word_done !== e.exp_wd) begin
                errors++;
                $display("FAIL word_done word=%h bit=%0d got=%b expected=%b",
                         e.word, e.idx, bus.word_done, e.exp_wd);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        bus.inp = 1'b0;

        // Reset with inp=1 must not set the state; next 1 passes through.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, -1);
        feed(16'h0001, 16);

        do_reset(); feed(16'h5772, 16);
        do_reset(); feed(16'h0000, 16);
        do_reset(); feed(16'h8000, 16);
        do_reset(); feed(16'h0001, 16);

        // Abort mid-word, then a fresh word with no carry-over.
        do_reset(); feed(16'h5772, 6);
        do_reset(); feed(16'h0002, 16);

        // Random words, each preceded by a reset.
        for (int n = 0; n < 30; n++) begin
            do_reset();
            feed(16'($urandom), 16);
        end

`ifdef TWOC_WORD_FRAME_EN
        // Back-to-back words with no reset between them.
        do_reset();
        feed(16'h5772, 16);
        feed(16'h0004, 16);
        for (int n = 0; n < 20; n++) begin
            feed(16'($urandom), 16);
        end
        // Abort inside a framed run, then resume framing.
        feed(16'h1234, 9);
        do_reset();
        feed(16'h8000, 16);
        feed(16'h0000, 16);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_twos_complement.md
Name: serial_twos_complement

Overview:
- Bit-serial two's-complement negator, implemented as a 2-state FSM with a registered output.
- Input word arrives LSB first, one bit per rising clock edge.
- Each output bit is the corresponding bit of the negated word: bits pass through unchanged up to and including the first 1, then every later bit is inverted.
- Sits between a serial shifter and a serial consumer in the datapath lab chain.

Parameters:
- WORD_WIDTH, 16, bits per serial word. Used only when TWOC_WORD_FRAME_EN is defined. Legal range ≥2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- inp  input  1  serial data bit, LSB first; sampled at the rising edge of clk.
- out  output  1  registered serial result bit for the inp sampled at the last edge.
- word_done  output  1  registered pulse marking the last bit of a word; see Optional Feature.

Behaviour:
- State register: seen_one. Encoding: PASS=0, INVERT=1.
- Reset (reset=1 at a rising edge): seen_one←0, out←0, word_done←0, bit counter←0. Reset has priority over all other activity.
  - Reset mid-word abandons the current word.
  - The next sampled bit is treated as the LSB of a new word.
- Normal edge (reset=0):
  - out ← seen_one ? ~inp : inp.
  - seen_one ← seen_one | inp.
- Latency:
  - out is valid after the rising edge that sampled inp, and stays stable until the next edge.
  - No combinational path from inp to out.
- Transitions:
  - PASS→INVERT when inp=1.
  - PASS stays PASS when inp=0.
  - INVERT is absorbing until reset, or until the word boundary when TWOC_WORD_FRAME_EN is defined.
- Boundary: an all-zero word produces an all-zero output; two's complement of 0 is 0, and seen_one never sets.
- Boundary: the most-negative value (MSB=1, all other bits 0) maps to itself; the first 1 is the MSB, so no inversions occur.
- No handshake: every clock edge consumes one bit.

Optional Feature:
- Macro: TWOC_WORD_FRAME_EN.
- Defined:
  - A bit counter, width $clog2(WORD_WIDTH), increments on every non-reset edge.
  - On the edge that consumes bit WORD_WIDTH-1:
    - word_done←1 for exactly one cycle.
    - Counter wraps to 0.
    - seen_one←0 regardless of inp.
    - out for that bit still uses the pre-edge seen_one.
  - Back-to-back words need no idle cycles and no reset between them.
- Not defined:
  - No counter.
  - word_done is tied to 0.
  - seen_one persists until reset, so each word must be preceded by a reset.

Test Plan:
- Reset held 1 for one edge with inp=1 -> out=0, word_done=0; seen_one remains 0, so the next inp=1 passes through as out=1.
- 16-bit word 0x5772 fed LSB first after reset -> out sequence LSB first 0,1,1,1,0,0,0,1,0,0,0,1,0,1,0,1 (0xA88E).
- Word 0x0000 -> out all 0; word 0x8000 -> out 0x8000, with the only 1 on bit 15.
- Word 0x0001 -> out LSB-first 1 followed by fifteen 1s (0xFFFF).
- Reset asserted after bit 5 of 0x5772, then 0x0002 fed -> out 0xFFFE; no carry-over from the aborted word.
- TWOC_WORD_FRAME_EN, WORD_WIDTH=16: 0x5772 then 0x0004 back-to-back with no reset -> 0xA88E then 0xFFFC; word_done high only after edges 16 and 32.
